imem_loader: RTL and testbench



---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_packer.sv | 35 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 tb/tb_imem_loader.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared instruction-memory parameters and the loader FSM encoding.
// The read side of the instruction memory uses the same ADDR_W.
package imem_pkg;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status.
// master = loader side, slave = byte source / memory / CPU side.
interface imem_loader_if;
  import imem_pkg::*;

  logic              start;
  logic              byte_vld;
  logic [7:0]        byte_dat;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_dat;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    input  start, byte_vld, byte_dat,
    output wr_en, wr_addr, wr_dat, cpu_hold, done, error
  );

  modport slave (
    output start, byte_vld, byte_dat,
    input  wr_en, wr_addr, wr_dat, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader_packer.sv
// Packs little-endian bytes into 32-bit words and XORs them into a checksum.
// word_next/word_ready are combinational on the lane-3 byte; no backpressure.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_dat,
  output logic [31:0] word_next,
  output logic        word_ready,
  output logic [7:0]  csum
);
  logic [1:0]  lane_cnt;
  logic [31:0] word_q;

  // Shifting in from the top leaves byte 0 in bits 7:0 after four bytes.
  assign word_next  = {byte_dat, word_q[31:8]};
  assign word_ready = en && (lane_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt <= 2'd0;
      word_q   <= 32'd0;
      csum     <= 8'd0;
    end else if (clr) begin
      lane_cnt <= 2'd0;
      word_q   <= 32'd0;
      csum     <= 8'd0;
    end else if (en) begin
      lane_cnt <= lane_cnt + 2'd1;
      word_q   <= word_next;
      csum     <= csum ^ byte_dat;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte-stream program image into instruction memory, holding the CPU in reset.
// Registered outputs, one write per 4 accepted payload bytes; input is never backpressured.
module imem_loader
  import imem_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  imem_loader_if.master  bus
);
  state_t            state, state_nxt;
  logic [7:0]        len_lo;
  logic [15:0]       len_full;
  logic [15:0]       rem;
  logic [ADDR_W-1:0] addr;

  logic        start_load, len_ld, rem_ld, wr_fire, go_done, go_err;
  logic        pack_clr, pack_en;
  logic [31:0] word_next;
  logic        word_ready;
  logic [7:0]  csum_acc;

  assign len_full = {bus.byte_dat, len_lo};

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pack_clr),
    .en         (pack_en),
    .byte_dat   (bus.byte_dat),
    .word_next  (word_next),
    .word_ready (word_ready),
    .csum       (csum_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_load = 1'b0;
    pack_clr   = 1'b0;
    pack_en    = 1'b0;
    len_ld     = 1'b0;
    rem_ld     = 1'b0;
    wr_fire    = 1'b0;
    go_done    = 1'b0;
    go_err     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // Bytes arriving here, including alongside start, are discarded.
        if (bus.start) begin
          start_load = 1'b1;
          pack_clr   = 1'b1;
          state_nxt  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (bus.byte_vld) begin
          len_ld    = 1'b1;
          state_nxt = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (bus.byte_vld) begin
          if (len_full == 16'd0 || len_full > 16'(MAX_WORDS)) begin
            go_err    = 1'b1;
            state_nxt = ST_ERR;
          end else begin
            rem_ld    = 1'b1;
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bus.byte_vld) begin
          pack_en = 1'b1;
          if (word_ready) begin
            wr_fire = 1'b1;
            if (rem == 16'd1) state_nxt = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (bus.byte_vld) begin
          if (bus.byte_dat == csum_acc) begin
            go_done   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            go_err    = 1'b1;
            state_nxt = ST_ERR;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo       <= 8'd0;
      rem          <= 16'd0;
      addr         <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_dat   <= 32'd0;
      bus.cpu_hold <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
    end else begin
      bus.wr_en <= wr_fire;
      if (len_ld) len_lo <= bus.byte_dat;
      if (rem_ld)       rem <= len_full;
      else if (wr_fire) rem <= rem - 16'd1;
      // wr_addr is only updated on a write so it holds the last address.
      if (wr_fire) begin
        bus.wr_addr <= addr;
        bus.wr_dat  <= word_next;
        addr        <= addr + ADDR_W'(1);
      end
      if (start_load) begin
        addr         <= '0;
        bus.cpu_hold <= 1'b1;
        bus.done     <= 1'b0;
        bus.error    <= 1'b0;
      end
      if (go_done) begin
        bus.done     <= 1'b1;
        bus.cpu_hold <= 1'b0;
      end
      if (go_err) begin
        bus.error    <= 1'b1;
        bus.cpu_hold <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Frame-level checks of imem_loader against a word-list reference model.
module tb_imem_loader;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if bus();
  imem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic        hold_at_start;
  logic [31:0] tx_words[$];
  int          wl_addr[$];
  logic [31:0] wl_dat[$];
  int          wl_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wl_addr.push_back(int'(bus.wr_addr));
      wl_dat.push_back(bus.wr_dat);
      wl_cyc.push_back(cyc);
    end
  end

  function automatic logic [7:0] model_csum();
    logic [7:0]  x;
    logic [31:0] w;
    x = 8'd0;
    foreach (tx_words[i]) begin
      w = tx_words[i];
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    return x;
  endfunction

  task automatic drive_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bus.byte_vld = 1'b1;
    bus.byte_dat = b;
    @(negedge clk);
    bus.byte_vld = 1'b0;
    bus.byte_dat = 8'($urandom);
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hold_at_start = bus.cpu_hold;
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [7:0] csum_flip,
                            input int gap_max, input bit do_start, input bit mid_start);
    logic [31:0] w;
    wl_addr.delete(); wl_dat.delete(); wl_cyc.delete();
    if (do_start) start_pulse();
    drive_byte(len[7:0],  $urandom_range(gap_max, 0));
    drive_byte(len[15:8], $urandom_range(gap_max, 0));
    if (tx_words.size() > 0) begin
      foreach (tx_words[i]) begin
        w = tx_words[i];
        for (int b = 0; b < 4; b++) begin
          if (mid_start && i == 0 && b == 2) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
          end
          drive_byte(w[8*b +: 8], $urandom_range(gap_max, 0));
        end
      end
      drive_byte(model_csum() ^ csum_flip, $urandom_range(gap_max, 0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.byte_vld = 1'b0; bus.byte_dat = 8'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.wr_en, bus.cpu_hold, bus.done, bus.error} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=0000", {bus.wr_en, bus.cpu_hold, bus.done, bus.error});
    end
    n_tests++;
    if (bus.wr_addr !== '0 || bus.wr_dat !== 32'd0) begin
      n_fail++; $display("FAIL reset_wr got addr=%0d dat=%h exp 0/0", bus.wr_addr, bus.wr_dat);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    tx_words.delete(); tx_words.push_back(32'h00100093);
    n_tests++;
    if (model_csum() !== 8'h83) begin
      n_fail++; $display("FAIL single_model_csum got=%h exp=83", model_csum());
    end
    send_frame(16'd1, 8'h00, 0, 1, 0);
    n_tests++;
    if (hold_at_start !== 1'b1) begin
      n_fail++; $display("FAIL single_hold_rise got=%b exp=1", hold_at_start);
    end
    n_tests++;
    if (wl_dat.size() != 1 || wl_addr[0] != 0 || wl_dat[0] !== 32'h00100093) begin
      n_fail++; $display("FAIL single_write got n=%0d exp n=1 addr=0 dat=00100093", wl_dat.size());
    end
    n_tests++;
    if ({bus.done, bus.error, bus.cpu_hold} !== 3'b100) begin
      n_fail++; $display("FAIL single_status got=%b exp=100", {bus.done, bus.error, bus.cpu_hold});
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] flip);
    tx_words.delete();
    tx_words.push_back(32'h00100093);
    tx_words.push_back(32'h0010006F);
    tx_words.push_back(32'h00200813);
    send_frame(16'd3, flip, 0, 1, 0);
    n_tests++;
    if (wl_dat.size() != 3) begin
      n_fail++; $display("FAIL b2b_count flip=%h got=%0d exp=3", flip, wl_dat.size());
    end
    for (int i = 0; i < 3 && i < wl_dat.size(); i++) begin
      n_tests++;
      if (wl_addr[i] != i || wl_dat[i] !== tx_words[i]) begin
        n_fail++; $display("FAIL b2b_write%0d got %0d/%h exp %0d/%h", i, wl_addr[i], wl_dat[i], i, tx_words[i]);
      end
      if (i > 0) begin
        n_tests++;
        if (wl_cyc[i] - wl_cyc[i-1] != 4) begin
          n_fail++; $display("FAIL b2b_spacing%0d got=%0d exp=4", i, wl_cyc[i] - wl_cyc[i-1]);
        end
      end
    end
    n_tests++;
    if ({bus.done, bus.error, bus.cpu_hold} !== ((flip == 8'h00) ? 3'b100 : 3'b010)) begin
      n_fail++; $display("FAIL b2b_status flip=%h got=%b", flip, {bus.done, bus.error, bus.cpu_hold});
    end
  endtask

  task automatic test_bad_len(input logic [15:0] len);
    tx_words.delete();
    send_frame(len, 8'h00, 0, 1, 0);
    n_tests++;
    if ({bus.done, bus.error, bus.cpu_hold} !== 3'b010 || hold_at_start !== 1'b1) begin
      n_fail++; $display("FAIL bad_len_%0d got status=%b hold0=%b exp 010/1", len, {bus.done, bus.error, bus.cpu_hold}, hold_at_start);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (wl_dat.size() != 0) begin
      n_fail++; $display("FAIL bad_len_%0d_writes got=%0d exp=0", len, wl_dat.size());
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int          n;
      logic [7:0]  flip;
      bit          exp_ok;
      int          bad;
      n = $urandom_range(6, 1);
      flip = ($urandom_range(2, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00;
      exp_ok = (flip == 8'h00);
      tx_words.delete();
      for (int i = 0; i < n; i++) tx_words.push_back($urandom);
      send_frame(16'(n), flip, 3, 1, f[0]);
      bad = 0;
      for (int i = 0; i < n && i < wl_dat.size(); i++)
        if (wl_addr[i] != i || wl_dat[i] !== tx_words[i]) bad++;
      n_tests++;
      if (wl_dat.size() != n || bad != 0) begin
        n_fail++; $display("FAIL rand%0d_writes got n=%0d bad=%0d exp n=%0d bad=0", f, wl_dat.size(), bad, n);
      end
      n_tests++;
      if ({bus.done, bus.error, bus.cpu_hold} !== (exp_ok ? 3'b100 : 3'b010)) begin
        n_fail++; $display("FAIL rand%0d_status got=%b exp_ok=%0d", f, {bus.done, bus.error, bus.cpu_hold}, exp_ok);
      end
    end
  endtask

  task automatic test_start_collision();
    bus.start = 1'b1; bus.byte_vld = 1'b1; bus.byte_dat = 8'h05;
    @(negedge clk);
    bus.start = 1'b0; bus.byte_vld = 1'b0;
    tx_words.delete(); tx_words.push_back(32'hDEADBEEF);
    send_frame(16'd1, 8'h00, 1, 0, 0);
    n_tests++;
    if (wl_dat.size() != 1 || wl_dat[0] !== 32'hDEADBEEF || bus.done !== 1'b1) begin
      n_fail++; $display("FAIL start_collision got n=%0d done=%b exp n=1 done=1", wl_dat.size(), bus.done);
    end
  endtask

  task automatic test_full();
    int bad;
    tx_words.delete();
    for (int i = 0; i < MAX_WORDS; i++) tx_words.push_back($urandom);
    send_frame(16'(MAX_WORDS), 8'h00, 0, 1, 0);
    bad = 0;
    for (int i = 0; i < MAX_WORDS && i < wl_dat.size(); i++)
      if (wl_addr[i] != i || wl_dat[i] !== tx_words[i]) bad++;
    n_tests++;
    if (wl_dat.size() != MAX_WORDS || bad != 0) begin
      n_fail++; $display("FAIL full_writes got n=%0d bad=%0d exp n=%0d bad=0", wl_dat.size(), bad, MAX_WORDS);
    end
    n_tests++;
    if (bus.wr_addr !== ADDR_W'(MAX_WORDS - 1) || bus.done !== 1'b1) begin
      n_fail++; $display("FAIL full_last got addr=%0d done=%b exp 1023/1", bus.wr_addr, bus.done);
    end
  endtask

  task automatic test_reset_mid_load();
    wl_addr.delete(); wl_dat.delete(); wl_cyc.delete();
    start_pulse();
    drive_byte(8'h02, 0);
    drive_byte(8'h00, 0);
    for (int b = 0; b < 6; b++) drive_byte(8'h11 * (b + 1), 0);
    n_tests++;
    if (wl_dat.size() != 1 || wl_dat[0] !== 32'h44332211) begin
      n_fail++; $display("FAIL midrst_pre_write got n=%0d exp n=1 dat=44332211", wl_dat.size());
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.wr_en, bus.cpu_hold, bus.done, bus.error} !== 4'b0000 || bus.wr_dat !== 32'd0 || bus.wr_addr !== '0) begin
      n_fail++; $display("FAIL midrst_outputs got flags=%b dat=%h exp 0", {bus.wr_en, bus.cpu_hold, bus.done, bus.error}, bus.wr_dat);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (wl_dat.size() != 1) begin
      n_fail++; $display("FAIL midrst_no_partial got n=%0d exp=1", wl_dat.size());
    end
    tx_words.delete(); tx_words.push_back(32'h0badf00d);
    send_frame(16'd1, 8'h00, 0, 1, 0);
    n_tests++;
    if (wl_dat.size() != 1 || wl_addr[0] != 0 || wl_dat[0] !== 32'h0badf00d || bus.done !== 1'b1) begin
      n_fail++; $display("FAIL midrst_reload got n=%0d done=%b exp n=1 addr=0 done=1", wl_dat.size(), bus.done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back(8'h00);
    test_back_to_back(8'h01);
    test_bad_len(16'h0000);
    test_bad_len(16'h0401);
    test_random();
    test_start_collision();
    test_full();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
